// File: rtl/key_sel_debounce.sv
// Two-channel key debouncer: 2-flop synchroniser, 4-state filter FSM per channel,
// one-cycle press pulse and a toggling select level that drives the LED switch.
module key_sel_debounce #(
  parameter int unsigned CNT_MAX    = 1_000_000,
  parameter bit          KEY_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_in,
  output logic [1:0] key_press,
  output logic       sel_a,
  output logic       sel_b
);

  localparam int unsigned     CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_FLT = 2'd1,
    DOWN      = 2'd2,
    REL_FLT   = 2'd3
  } state_t;

  logic [1:0] sel_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic          sync1_q, sync1_d;
      logic          key_s_q, key_s_d;
      logic          pressed;
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          press_q, press_d;
      logic          sel_q, sel_d;

      always_comb begin
        sync1_d = key_in[gi];
        key_s_d = sync1_q;
      end

      assign pressed = (key_s_q == KEY_ACTIVE);

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        sel_d   = sel_q;
        case (state_q)
          IDLE: begin
            if (pressed) begin
              state_d = PRESS_FLT;
              cnt_d   = '0;
            end
          end
          PRESS_FLT: begin
            // A single released sample is a glitch and restarts the filter.
            if (!pressed) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = DOWN;
              cnt_d   = '0;
              press_d = 1'b1;
              sel_d   = ~sel_q;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          DOWN: begin
            if (!pressed) begin
              state_d = REL_FLT;
              cnt_d   = '0;
            end
          end
          REL_FLT: begin
            // Re-press during release filtering returns silently to DOWN.
            if (pressed) begin
              state_d = DOWN;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= ~KEY_ACTIVE;
          key_s_q <= ~KEY_ACTIVE;
          state_q <= IDLE;
          cnt_q   <= '0;
          press_q <= 1'b0;
          sel_q   <= 1'b0;
        end else begin
          sync1_q <= sync1_d;
          key_s_q <= key_s_d;
          state_q <= state_d;
          cnt_q   <= cnt_d;
          press_q <= press_d;
          sel_q   <= sel_d;
        end
      end

      assign key_press[gi] = press_q;
      assign sel_vec[gi]   = sel_q;
    end
  endgenerate

  assign sel_a = sel_vec[0];
  assign sel_b = sel_vec[1];

endmodule

// File: tb/tb_key_sel_debounce.sv
// Bench for key_sel_debounce: directed scenarios with literal timing checks plus
// random key activity compared every cycle against a sliding-window reference model.
module tb_key_sel_debounce;

  localparam int unsigned N          = 8;
  localparam bit          KEY_ACTIVE = 1'b0;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_in;
  logic [1:0] key_press;
  logic       sel_a;
  logic       sel_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int hold_cnt [2];

  key_sel_debounce #(.CNT_MAX(N), .KEY_ACTIVE(KEY_ACTIVE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_press (key_press),
    .sel_a     (sel_a),
    .sel_b     (sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a debounced level flips when the last N+1 synchronised
  // samples all disagree with it; synchronised sample = key_in two edges ago.
  logic [1:0] kin_hist [$];
  logic [1:0] ks_hist  [$];
  logic [1:0] deb;
  logic [1:0] exp_press;
  logic [1:0] exp_sel;
  logic [1:0] mdl_ks;
  logic       all_p;
  logic       all_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kin_hist.delete();
      ks_hist.delete();
      deb       = 2'b00;
      exp_press = 2'b00;
      exp_sel   = 2'b00;
    end else begin
      mdl_ks = (kin_hist.size() == 2) ? kin_hist[0] : 2'b00;
      kin_hist.push_back(KEY_ACTIVE ? key_in : ~key_in);
      if (kin_hist.size() > 2) void'(kin_hist.pop_front());
      ks_hist.push_back(mdl_ks);
      if (ks_hist.size() > N + 1) void'(ks_hist.pop_front());
      exp_press = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (ks_hist.size() == N + 1) begin
          all_p = 1'b1;
          all_r = 1'b1;
          foreach (ks_hist[j]) begin
            all_p = all_p & ks_hist[j][i];
            all_r = all_r & ~ks_hist[j][i];
          end
          if (!deb[i] && all_p) begin
            deb[i]       = 1'b1;
            exp_press[i] = 1'b1;
            exp_sel[i]   = ~exp_sel[i];
          end else if (deb[i] && all_r) begin
            deb[i] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, plus pulse bookkeeping.
  always @(posedge clk) begin
    #1;
    chk("key_press_vs_model", {6'b0, key_press}, {6'b0, exp_press});
    chk("sel_vs_model", {6'b0, sel_b, sel_a}, {6'b0, exp_sel});
    if (key_press != 2'b00) begin
      pulses_a = pulses_a + int'(key_press[0]);
      pulses_b = pulses_b + int'(key_press[1]);
      $display("t=%0t pulse key_press=%b sel_a=%b sel_b=%b", $time, key_press, sel_a, sel_b);
    end
  end

  // Next posedge is the first sampling edge E of a held press; pulse due at E+N+2.
  task automatic press_check(input string tag, input logic [1:0] exp_pulse, input logic [1:0] sel_before);
    for (int k = 0; k <= N + 3; k++) begin
      @(posedge clk);
      #2;
      if (k < N + 2) begin
        chk({tag, "_no_early_pulse"}, {6'b0, key_press}, 8'h00);
        chk({tag, "_sel_hold"}, {6'b0, sel_b, sel_a}, {6'b0, sel_before});
      end else if (k == N + 2) begin
        chk({tag, "_pulse"}, {6'b0, key_press}, {6'b0, exp_pulse});
        chk({tag, "_sel_toggle"}, {6'b0, sel_b, sel_a}, {6'b0, sel_before ^ exp_pulse});
      end else begin
        chk({tag, "_pulse_end"}, {6'b0, key_press}, 8'h00);
      end
    end
    $display("t=%0t %s press sequence done", $time, tag);
  endtask

  task automatic do_reset(input logic [1:0] k);
    @(negedge clk);
    rst_n  = 1'b0;
    key_in = k;
    #1;
    chk("reset_clear_press", {6'b0, key_press}, 8'h00);
    chk("reset_clear_sel", {6'b0, sel_b, sel_a}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = 2'b11;
    repeat (3) @(negedge clk);
    key_in = 2'b10;
    @(negedge clk);
    chk("in_reset_press", {6'b0, key_press}, 8'h00);
    chk("in_reset_sel", {6'b0, sel_b, sel_a}, 8'h00);

    // Clean press on A, held through reset release.
    rst_n = 1'b1;
    press_check("clean_a", 2'b01, 2'b00);

    // Bounce on B while A is released.
    @(negedge clk);
    key_in = 2'b11;
    repeat (15) @(negedge clk);
    pulses_b = 0;
    for (int c = 0; c < 40; c++) begin
      key_in[1] = ((c % 6) < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    key_in[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("bounce_b_pulses", 8'(pulses_b), 8'd0);
    chk("bounce_b_sel", {7'b0, sel_b}, 8'h00);
    $display("t=%0t bounce phase done", $time);

    // Long hold and second press on A.
    do_reset(2'b11);
    @(negedge clk);
    pulses_a = 0;
    key_in[0] = 1'b0;
    repeat (100) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (20) @(negedge clk);
    key_in[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("long_hold_pulses", 8'(pulses_a), 8'd2);
    chk("long_hold_sel_a", {7'b0, sel_a}, 8'h00);
    $display("t=%0t long hold phase done", $time);

    // Release bounce while in DOWN, then a clean release and a fresh press.
    pulses_a = 0;
    key_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    key_in[0] = 1'b0;
    repeat (20) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("release_bounce_pulses", 8'(pulses_a), 8'd0);
    key_in[0] = 1'b0;
    press_check("after_release", 2'b01, 2'b00);

    // Simultaneous press on both channels straight out of reset.
    @(negedge clk);
    key_in = 2'b11;
    repeat (15) @(negedge clk);
    do_reset(2'b00);
    press_check("both", 2'b11, 2'b00);

    // Reset while A is mid-filter (cnt = 5 in PRESS_FLT).
    @(negedge clk);
    key_in = 2'b11;
    repeat (15) @(negedge clk);
    key_in = 2'b10;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midfilter_clear_press", {6'b0, key_press}, 8'h00);
    chk("midfilter_clear_sel", {6'b0, sel_b, sel_a}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    press_check("after_midfilter_reset", 2'b01, 2'b00);

    // Random key activity with occasional resets, checked by the model.
    @(negedge clk);
    key_in = 2'b11;
    hold_cnt[0] = 5;
    hold_cnt[1] = 9;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (hold_cnt[i] == 0) begin
          key_in[i]   = ~key_in[i];
          hold_cnt[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(9, 30))
                                                    : int'($urandom_range(0, 12));
        end else begin
          hold_cnt[i] = hold_cnt[i] - 1;
        end
      end
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end
    rst_n  = 1'b1;
    key_in = 2'b11;
    repeat (30) @(negedge clk);
    $display("t=%0t random phase done", $time);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_sel_debounce.md
# key_sel_debounce

Two-channel push-button debouncer and toggle generator that drives the `sel_a` / `sel_b` select inputs of the 2-to-1 LED data switch directly downstream. Each raw key input is synchronised, filtered by a per-channel debounce state machine, and converted into a one-cycle press pulse. Each press pulse also flips a registered select level. The select levels feed the switch unchanged; the pulses are available for LED/status logic.

## Interface
- `CNT_MAX`, default 1_000_000: debounce window in clock cycles (20 ms at 50 MHz); legal range ≥ 2.
- `KEY_ACTIVE`, default 0: pressed level of `key_in` (0 = active-low buttons).
- `clk`  input  1  system clock, all logic on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `key_in`  input  2  raw, asynchronous button levels; bit 0 → channel A, bit 1 → channel B.
- `key_press`  output  2  registered one-cycle pulse per channel on an accepted press.
- `sel_a`  output  1  registered toggle level for channel A, to switch `sel_a`.
- `sel_b`  output  1  registered toggle level for channel B, to switch `sel_b`.

## Operation
- Reset values:
  - `key_press`=2'b00, `sel_a`=0, `sel_b`=0.
  - Both FSMs in IDLE, counters 0.
  - Synchroniser flops hold the released level (`~KEY_ACTIVE`).
- Synchroniser: two flops per channel. Only the second-stage output (`key_s`) is used downstream.
- Counter: one per channel, width `$clog2(CNT_MAX)`. It never exceeds CNT_MAX-1, so there is no wrap.
- Per-channel FSM, four states:
  - IDLE (stable released):
    - `key_s` pressed → PRESS_FLT, cnt←0.
  - PRESS_FLT:
    - `key_s` released → IDLE, cnt←0. This is a glitch and is rejected.
    - Otherwise, if cnt==CNT_MAX-1 → DOWN, assert that channel's `key_press` bit, and invert that channel's sel output.
    - Otherwise cnt←cnt+1.
  - DOWN (stable pressed):
    - `key_s` released → REL_FLT, cnt←0.
  - REL_FLT:
    - `key_s` pressed → DOWN, cnt←0. No pulse and no toggle.
    - Otherwise, if cnt==CNT_MAX-1 → IDLE.
    - Otherwise cnt←cnt+1.
- A held key produces exactly one pulse and one toggle, however long it is held.
- Channels are fully independent. Simultaneous accepted presses give `key_press`=2'b11 and toggle both selects in the same cycle.
- Releases never pulse and never toggle.
- Reset asserted mid-filter or mid-hold:
  - All state returns to reset values immediately (asynchronously).
  - No pulse is emitted on reset release.
  - A key still held at reset release is treated as a new press once synchronised and filtered.

## Timing
- Let E be the rising edge at which `key_in` is first sampled pressed, and assume it is held.
  - `key_s` is pressed after edge E+1.
  - The FSM enters PRESS_FLT at edge E+2.
  - `key_press` bit and sel toggle are registered at edge E+CNT_MAX+2.
  - `key_press` deasserts at edge E+CNT_MAX+3.
- Acceptance requires the pressed level on `key_s` for CNT_MAX+1 consecutive cycles. One released sample restarts the filter.
- Release acceptance has the same rule. After a release is accepted (IDLE reached), the next press again takes CNT_MAX+1 stable cycles.
- `sel_a` / `sel_b` change only in the same cycle as the corresponding `key_press` pulse.
- Outputs are glitch-free registers. The downstream switch sees a new select level on the cycle after the pulse edge.

## Test plan
- Reset and clean press, CNT_MAX=8, KEY_ACTIVE=0:
  - Stimulus: hold `rst_n`=0 while `key_in`=2'b10, then release reset. `key_in[0]`→0 at edge E and held.
  - Required: outputs 0 during reset; `key_press`=2'b01 for exactly one cycle at E+10; `sel_a` 0→1 at E+10; `sel_b` stays 0.
- Bounce rejection:
  - Stimulus: `key_in[1]` toggles pressed/released every 3 cycles for 40 cycles, then stays released.
  - Required: `key_press[1]` never asserts and `sel_b` stays 0.
- Long hold and second press:
  - Stimulus: hold channel A 100 cycles, release 20 cycles, press again and hold.
  - Required: exactly two pulses in total; `sel_a` ends at 0 (toggled 0→1→0).
- Release bounce:
  - Stimulus: in DOWN, release for 4 cycles, re-press for 20 cycles, then release cleanly.
  - Required: no extra pulse; the FSM returns to DOWN, then to IDLE CNT_MAX+1 cycles after the final clean release as seen on `key_s`.
- Simultaneous channels:
  - Stimulus: both keys pressed on the same edge E.
  - Required: `key_press`=2'b11 at E+10; `sel_a`=`sel_b`=1 on the same cycle.
- Reset mid-filter:
  - Stimulus: assert `rst_n`=0 when cnt=5 in PRESS_FLT, with the key held; release reset at edge R.
  - Required: outputs clear immediately; no pulse before R+10; pulse and toggle at R+10, counting R as the first sampling edge.
